// File: rtl/definitions.sv
// Shared fixed-point definitions for the MAC datapath: Q format, operating
// modes and the saturating clamp to Q width.
package definitions;

  localparam int Q_INT      = 8;
  localparam int Q_FRAC     = 8;
  localparam int Q_SIZE     = Q_INT + Q_FRAC;
  localparam int CLAMP_IN_W = 64;

  typedef enum logic {
    MODE_ACC = 1'b0,
    MODE_MUL = 1'b1
  } mac_mode_t;

  typedef struct packed {
    logic              sat;
    logic [Q_SIZE-1:0] q;
  } q_clamp_t;

  localparam logic signed [CLAMP_IN_W-1:0] Q_MAX_EXT =
    {{(CLAMP_IN_W-Q_SIZE+1){1'b0}}, {(Q_SIZE-1){1'b1}}};
  localparam logic signed [CLAMP_IN_W-1:0] Q_MIN_EXT =
    {{(CLAMP_IN_W-Q_SIZE+1){1'b1}}, {(Q_SIZE-1){1'b0}}};

  // Caller sign-extends its value to CLAMP_IN_W bits.
  function automatic q_clamp_t q_clamp(input logic signed [CLAMP_IN_W-1:0] v);
    q_clamp_t r;
    r.sat = 1'b0;
    r.q   = v[Q_SIZE-1:0];
    if (v > Q_MAX_EXT) begin
      r.sat = 1'b1;
      r.q   = {1'b0, {(Q_SIZE-1){1'b1}}};
    end else if (v < Q_MIN_EXT) begin
      r.sat = 1'b1;
      r.q   = {1'b1, {(Q_SIZE-1){1'b0}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: rounded product register, guard-extended saturating
// accumulator with sticky sat, and clamp of the next sum to Q format.
module mac_lane
  import definitions::*;
#(
  parameter int ACC_GUARD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_p,
  input  logic              acc_en,
  input  logic              first,
  input  logic [Q_SIZE-1:0] x,
  input  logic [Q_SIZE-1:0] w,
  output logic [Q_SIZE-1:0] q,
  output logic              sat
);

  localparam int FULL_W = 2 * Q_SIZE;
  localparam int PROD_W = 2 * Q_INT + Q_FRAC;
  localparam int ACC_W  = PROD_W + ACC_GUARD;
  localparam logic [FULL_W-1:0] ROUND_HALF = FULL_W'(1) << (Q_FRAC - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [FULL_W-1:0] x_ext;
  logic signed [FULL_W-1:0] w_ext;
  logic signed [FULL_W-1:0] full_prod;
  logic [PROD_W-1:0]        prod_round;
  logic [Q_FRAC-1:0]        frac_unused;
  logic [PROD_W-1:0]        prod_reg;
  logic [ACC_W-1:0]         acc_reg;
  logic [ACC_W-1:0]         acc_next;
  logic [ACC_W:0]           acc_ext;
  logic [ACC_W:0]           prod_ext;
  logic [ACC_W:0]           sum;
  logic                     acc_ovf;
  logic                     sticky_reg;
  logic                     sticky_next;
  q_clamp_t                 clamp;

  assign x_ext     = {{(FULL_W-Q_SIZE){x[Q_SIZE-1]}}, x};
  assign w_ext     = {{(FULL_W-Q_SIZE){w[Q_SIZE-1]}}, w};
  assign full_prod = x_ext * w_ext;
  // Round half up, then drop the fraction bits below the Q point.
  assign {prod_round, frac_unused} = full_prod + ROUND_HALF;

  assign prod_ext = {{(ACC_W+1-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
  assign acc_ext  = {acc_reg[ACC_W-1], acc_reg};

  always_comb begin
    sum = acc_ext + prod_ext;
    if (first) sum = prod_ext;
    acc_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
    acc_next = sum[ACC_W-1:0];
    if (acc_ovf) acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    sticky_next = (sticky_reg & ~first) | acc_ovf;
    clamp = q_clamp({{(CLAMP_IN_W-ACC_W){acc_next[ACC_W-1]}}, acc_next});
  end

  assign q   = clamp.q;
  assign sat = sticky_next | clamp.sat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_reg   <= '0;
      acc_reg    <= '0;
      sticky_reg <= 1'b0;
    end else begin
      if (load_p) prod_reg <= prod_round;
      if (acc_en) begin
        acc_reg    <= acc_next;
        sticky_reg <= sticky_next;
      end
    end
  end

endmodule

// File: rtl/mac_lane_array.sv
// Multi-lane pipelined MAC: broadcast activation, per-lane weights, vector
// framing, output register and a single global stall.
module mac_lane_array
  import definitions::*;
#(
  parameter int LANES     = 4,
  parameter int ACC_GUARD = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic                    in_mode,
  input  logic [Q_SIZE-1:0]       in_x,
  input  logic [LANES*Q_SIZE-1:0] in_w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*Q_SIZE-1:0] out_data,
  output logic [LANES-1:0]        out_sat
);

  logic                    stall;
  logic                    advance;
  logic                    beat;
  logic                    beat_last;
  logic                    open_reg;
  logic                    p_valid_reg;
  logic                    p_first_reg;
  logic                    p_last_reg;
  logic                    out_valid_reg;
  logic [LANES*Q_SIZE-1:0] out_data_reg;
  logic [LANES-1:0]        out_sat_reg;
  logic [LANES*Q_SIZE-1:0] lane_q;
  logic [LANES-1:0]        lane_sat;

  assign stall    = out_valid_reg & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;
  assign beat     = in_valid & advance;
  // Mode only matters on the opening beat; a multiply beat closes its vector.
  assign beat_last = in_last | (open_reg & (mac_mode_t'(in_mode) == MODE_MUL));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane #(
        .ACC_GUARD(ACC_GUARD)
      ) u_lane (
        .clk    (clk),
        .reset_n(reset_n),
        .load_p (advance),
        .acc_en (advance & p_valid_reg),
        .first  (p_first_reg),
        .x      (in_x),
        .w      (in_w[gi*Q_SIZE +: Q_SIZE]),
        .q      (lane_q[gi*Q_SIZE +: Q_SIZE]),
        .sat    (lane_sat[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_reg      <= 1'b1;
      p_valid_reg   <= 1'b0;
      p_first_reg   <= 1'b0;
      p_last_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= '0;
    end else if (advance) begin
      p_valid_reg <= beat;
      p_first_reg <= open_reg;
      p_last_reg  <= beat_last;
      if (beat) open_reg <= beat_last;
      if (p_valid_reg && p_last_reg) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= lane_q;
        out_sat_reg   <= lane_sat;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_mac_lane_array.sv
// Bench for mac_lane_array: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic model of the lane results.
module tb_mac_lane_array;
  import definitions::*;

  localparam int LANES     = 4;
  localparam int ACC_GUARD = 4;
  localparam int QS        = Q_SIZE;
  localparam int ACC_W     = 2 * Q_INT + ACC_GUARD + Q_FRAC;
  localparam longint AMAX  = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint AMIN  = -AMAX - 1;
  localparam longint QMAX  = (longint'(1) <<< (QS - 1)) - 1;
  localparam longint QMIN  = -QMAX - 1;

  logic                clk;
  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic                in_mode;
  logic [QS-1:0]       in_x;
  logic [LANES*QS-1:0] in_w;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*QS-1:0] out_data;
  logic [LANES-1:0]    out_sat;

  mac_lane_array #(
    .LANES    (LANES),
    .ACC_GUARD(ACC_GUARD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_mode  (in_mode),
    .in_x     (in_x),
    .in_w     (in_w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [LANES*QS-1:0] data;
    logic [LANES-1:0]    sat;
    int                  cyc;
  } exp_t;

  exp_t   expq[$];
  longint m_acc[LANES];
  bit     m_sat[LANES];
  bit     m_open = 1'b1;
  int     cyc = 0;
  int     n_results = 0;

  bit                  s_beat = 1'b0;
  bit                  s_pop  = 1'b0;
  logic [QS-1:0]       s_x;
  logic [LANES*QS-1:0] s_w;
  logic                s_last;
  logic                s_mode;

  task automatic model_beat(input logic [QS-1:0] x, input logic [LANES*QS-1:0] w,
                            input logic last, input logic mode);
    bit   first;
    bit   done;
    exp_t e;
    first  = m_open;
    done   = last || (first && mode);
    e.data = '0;
    e.sat  = '0;
    e.cyc  = cyc;
    for (int i = 0; i < LANES; i++) begin
      longint xv;
      longint wv;
      longint p;
      longint qv;
      xv = longint'($signed(x));
      wv = longint'($signed(w[i*QS +: QS]));
      p  = (xv * wv + (longint'(1) <<< (Q_FRAC - 1))) >>> Q_FRAC;
      if (first) begin
        m_acc[i] = p;
        m_sat[i] = 1'b0;
      end else begin
        m_acc[i] = m_acc[i] + p;
        if (m_acc[i] > AMAX) begin m_acc[i] = AMAX; m_sat[i] = 1'b1; end
        else if (m_acc[i] < AMIN) begin m_acc[i] = AMIN; m_sat[i] = 1'b1; end
      end
      if (done) begin
        qv = m_acc[i];
        if (qv > QMAX) begin qv = QMAX; m_sat[i] = 1'b1; end
        else if (qv < QMIN) begin qv = QMIN; m_sat[i] = 1'b1; end
        e.data[i*QS +: QS] = qv[QS-1:0];
        e.sat[i] = m_sat[i];
      end
    end
    if (done) expq.push_back(e);
    m_open = done;
  endtask

  // Inputs change just after posedge, so a negedge snapshot is what the next edge sees.
  always @(negedge clk) begin
    if (!reset_n) begin
      expq.delete();
      m_open = 1'b1;
      s_beat = 1'b0;
      s_pop  = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_sat", 64'(out_sat), 64'd0);
    end else begin
      cyc++;
      if (s_pop && expq.size() > 0) begin
        $display("result %0d: data=%h sat=%b", n_results, expq[0].data, expq[0].sat);
        n_results++;
        void'(expq.pop_front());
      end
      if (s_beat) model_beat(s_x, s_w, s_last, s_mode);
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("model_data", 64'(out_data), 64'(expq[0].data));
          chk("model_sat", 64'(out_sat), 64'(expq[0].sat));
          if (expq[0].cyc == cyc) chk("early_valid", 64'(out_valid), 64'd0);
        end
      end else if (expq.size() > 0 && expq[0].cyc < cyc) begin
        chk("late_valid", 64'(out_valid), 64'd1);
      end
      s_pop  = out_valid && out_ready;
      s_beat = in_valid && in_ready;
      s_x    = in_x;
      s_w    = in_w;
      s_last = in_last;
      s_mode = in_mode;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*QS-1:0] wpack(input logic [QS-1:0] w0, input logic [QS-1:0] w1);
    logic [LANES*QS-1:0] r;
    r = '0;
    r[QS-1:0]    = w0;
    r[2*QS-1:QS] = w1;
    return r;
  endfunction

  function automatic logic [QS-1:0] rnd16();
    logic [QS-1:0] v;
    if ($urandom_range(0, 2) == 0) v = QS'($urandom);
    else v = QS'(int'($urandom_range(0, 2047)) - 1024);
    return v;
  endfunction

  task automatic send(input logic [QS-1:0] x, input logic [LANES*QS-1:0] w,
                      input logic last, input logic mode);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    in_last  = last;
    in_mode  = mode;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at %0b, expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [QS-1:0] l0,
                               input logic [QS-1:0] l1, input logic [LANES-1:0] sat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_lane0"}, 64'(out_data[QS-1:0]), 64'(l0));
    chk({name, "_lane1"}, 64'(out_data[2*QS-1:QS]), 64'(l1));
    chk({name, "_sat"}, 64'(out_sat), 64'(sat));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_mode   = MODE_ACC;
    in_x      = '0;
    in_w      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Three-beat accumulate with latency check.
    send(16'h0100, wpack(16'h0200, 16'hFF00), 1'b0, MODE_ACC);
    send(16'h0100, wpack(16'h0200, 16'hFF00), 1'b0, MODE_ACC);
    send(16'h0100, wpack(16'h0200, 16'hFF00), 1'b1, MODE_ACC);
    @(negedge clk);
    chk("lat_before", 64'(out_valid), 64'd0);
    tick();
    chk("lat_after", 64'(out_valid), 64'd1);
    chk("acc3_lane0", 64'(out_data[QS-1:0]), 64'h0600);
    chk("acc3_lane1", 64'(out_data[2*QS-1:QS]), 64'hFD00);
    chk("acc3_sat", 64'(out_sat), 64'd0);
    tick();

    // Output saturation both directions.
    send(16'h7F00, wpack(16'h7F00, 16'h8100), 1'b0, MODE_MUL);
    expect_result("sat", 16'h7FFF, 16'h8000, 4'b0011);

    // Guard bits absorb an out-of-range intermediate sum.
    send(16'h6400, wpack(16'h0100, 16'h0100), 1'b0, MODE_ACC);
    send(16'h6400, wpack(16'h0100, 16'h0100), 1'b0, MODE_ACC);
    send(16'h9C00, wpack(16'h0100, 16'h0100), 1'b0, MODE_ACC);
    send(16'h9C00, wpack(16'h0100, 16'h0100), 1'b1, MODE_ACC);
    expect_result("guard", 16'h0000, 16'h0000, 4'b0000);

    // Rounding half up.
    send(16'h0001, wpack(16'h0080, 16'h007F), 1'b0, MODE_MUL);
    expect_result("round_pos", 16'h0001, 16'h0000, 4'b0000);
    send(16'hFFFF, wpack(16'h0080, 16'h0081), 1'b0, MODE_MUL);
    expect_result("round_neg", 16'h0000, 16'hFFFF, 4'b0000);

    // Reset in the middle of a vector.
    send(16'h0100, wpack(16'h0500, 16'h0000), 1'b0, MODE_ACC);
    send(16'h0100, wpack(16'h0500, 16'h0000), 1'b0, MODE_ACC);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    reset_n = 1'b1;
    send(16'h0100, wpack(16'h0200, 16'h0000), 1'b1, MODE_ACC);
    expect_result("after_rst", 16'h0200, 16'h0000, 4'b0000);

    // Backpressure: result A held while B sits in the pipe and C waits.
    out_ready = 1'b0;
    send(16'h0100, wpack(16'h0300, 16'h0000), 1'b0, MODE_MUL);
    in_valid = 1'b1;
    in_x     = 16'h0200;
    in_mode  = MODE_MUL;
    tick();
    in_x = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_lane0", 64'(out_data[QS-1:0]), 64'h0300);
    end
    tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second", 64'(out_data[QS-1:0]), 64'h0600);
    tick();
    @(negedge clk);
    chk("bp_third", 64'(out_data[QS-1:0]), 64'h0900);
    tick();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_last  = ($urandom_range(0, 3) == 0);
      in_mode  = ($urandom_range(0, 4) == 0);
      in_x     = rnd16();
      for (int l = 0; l < LANES; l++) in_w[l*QS +: QS] = rnd16();
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("drain_empty", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
